// File: rtl/matmul_pkg.sv
// Shared state encoding and default sizing for the matmul controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_WB   = 3'd3,
    S_POST = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam int         DEF_N_MUL    = 4;
  localparam int         DEF_N_ROWS   = 4;
  localparam logic [7:0] DEF_RAM_BASE = 8'h00;

endpackage

// File: rtl/matmul_ctrl_if.sv
// Handshake/bus bundle between the matmul controller and its datapath/SRAM.
// Latency: n/a (wires only).
// Backpressure: ry from the SRAM side stalls write-back.
interface matmul_ctrl_if;
  logic       start;
  logic       xload_done;
  logic       ry;
  logic       input_load_en;
  logic       AU_en;
  logic [3:0] rom_addr;
  logic       cs_n;
  logic       we_n;
  logic [7:0] ram_addr;
  logic       row_done;
  logic       avgmax_en;
  logic       busy;
  logic       done;

  // Controller side
  modport master (
    input  start, xload_done, ry,
    output input_load_en, AU_en, rom_addr, cs_n, we_n, ram_addr,
           row_done, avgmax_en, busy, done
  );

  // Environment side
  modport slave (
    output start, xload_done, ry,
    input  input_load_en, AU_en, rom_addr, cs_n, we_n, ram_addr,
           row_done, avgmax_en, busy, done
  );
endinterface

// File: rtl/matmul_addr_gen.sv
// Row/mul counters producing coefficient ROM and SRAM write addresses.
// Latency: addresses are combinational from the registered counters.
// Backpressure: counters only move on mul_inc/row_inc from the FSM.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int         N_MUL    = DEF_N_MUL,
  parameter int         N_ROWS   = DEF_N_ROWS,
  parameter logic [7:0] RAM_BASE = DEF_RAM_BASE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       mul_inc,
  input  logic       row_inc,
  output logic [3:0] rom_addr,
  output logic [7:0] ram_addr,
  output logic       last_mul,
  output logic       last_row
);

  logic [2:0] mul_q, mul_d;
  logic [3:0] row_q, row_d;

  assign last_mul = (mul_q == 3'(N_MUL - 1));
  assign last_row = (row_q == 4'(N_ROWS - 1));
  // N_ROWS*N_MUL <= 16 keeps the ROM address inside 4 bits
  assign rom_addr = row_q * 4'(N_MUL) + 4'(mul_q);
  // 8-bit add wraps naturally past 8'hFF
  assign ram_addr = RAM_BASE + 8'(row_q);

  // Next counter values: clear wins, mul wraps at the end of each row
  always_comb begin
    mul_d = mul_q;
    row_d = row_q;
    if (clr) begin
      mul_d = '0;
      row_d = '0;
    end else begin
      if (mul_inc) mul_d = last_mul ? 3'd0 : mul_q + 3'd1;
      if (row_inc) row_d = row_q + 4'd1;
    end
  end

  // Counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      mul_q <= '0;
      row_q <= '0;
    end else begin
      mul_q <= mul_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/matmul_ctrl.sv
// Sequences X load, per-row MAC bursts and SRAM write-back for a matmul job.
// Latency: 1 + load + N_ROWS*(N_MUL + 1 + stalls) [+1 POST] + 1 DONE cycles.
// Backpressure: ry=0 holds WB with the SRAM idle; start while busy is dropped.
// Optional feature: MATMUL_CTRL_AVGMAX_EN adds a one-cycle POST state.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int         N_MUL    = DEF_N_MUL,
  parameter int         N_ROWS   = DEF_N_ROWS,
  parameter logic [7:0] RAM_BASE = DEF_RAM_BASE
) (
  input  logic          clk,
  input  logic          rst,
  matmul_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic       clr, mul_inc, row_inc;
  logic       last_mul, last_row;
  logic [3:0] rom_addr_raw;
  logic [7:0] ram_addr_raw;
  logic       input_load_en, au_en, cs_n, we_n, row_done, avgmax_en, done;

  matmul_addr_gen #(
    .N_MUL    (N_MUL),
    .N_ROWS   (N_ROWS),
    .RAM_BASE (RAM_BASE)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .mul_inc  (mul_inc),
    .row_inc  (row_inc),
    .rom_addr (rom_addr_raw),
    .ram_addr (ram_addr_raw),
    .last_mul (last_mul),
    .last_row (last_row)
  );

  // Next-state and Moore/Mealy outputs; everything idles by default
  always_comb begin
    state_d       = state_q;
    input_load_en = 1'b0;
    au_en         = 1'b0;
    cs_n          = 1'b1;
    we_n          = 1'b1;
    row_done      = 1'b0;
    avgmax_en     = 1'b0;
    done          = 1'b0;
    clr           = 1'b0;
    mul_inc       = 1'b0;
    row_inc       = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr = 1'b1;
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        input_load_en = 1'b1;
        if (bus.xload_done) state_d = S_MAC;
      end
      S_MAC: begin
        au_en   = 1'b1;
        mul_inc = 1'b1;
        if (last_mul) state_d = S_WB;
      end
      S_WB: begin
        // SRAM strobes only on a ready cycle; otherwise hold here
        if (bus.ry) begin
          cs_n     = 1'b0;
          we_n     = 1'b0;
          row_done = 1'b1;
          if (last_row) begin
`ifdef MATMUL_CTRL_AVGMAX_EN
            state_d = S_POST;
`else
            state_d = S_DONE;
`endif
          end else begin
            row_inc = 1'b1;
            state_d = S_MAC;
          end
        end
      end
      S_POST: begin
`ifdef MATMUL_CTRL_AVGMAX_EN
        avgmax_en = 1'b1;
        state_d   = S_DONE;
`else
        state_d   = S_IDLE;
`endif
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  assign bus.input_load_en = input_load_en;
  assign bus.AU_en         = au_en;
  assign bus.rom_addr      = (state_q == S_MAC) ? rom_addr_raw : 4'd0;
  assign bus.cs_n          = cs_n;
  assign bus.we_n          = we_n;
  assign bus.ram_addr      = (state_q == S_WB) ? ram_addr_raw : RAM_BASE;
  assign bus.row_done      = row_done;
  assign bus.avgmax_en     = avgmax_en;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = done;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: default instance plus a RAM_BASE=8'hFE copy
// sharing the same stimulus, so both walk the same job in lockstep.
// Expectations follow MATMUL_CTRL_AVGMAX_EN when it is defined for the build.
module tb_matmul_ctrl;

  localparam int NM = 4;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;
  logic start, xload_done, ry;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  matmul_ctrl_if bus0 ();
  matmul_ctrl_if bus1 ();

  assign bus0.start      = start;
  assign bus0.xload_done = xload_done;
  assign bus0.ry         = ry;
  assign bus1.start      = start;
  assign bus1.xload_done = xload_done;
  assign bus1.ry         = ry;

  matmul_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  matmul_ctrl #(
    .N_MUL    (4),
    .N_ROWS   (4),
    .RAM_BASE (8'hFE)
  ) u_dut_fe (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always @(posedge clk) begin
    if (bus0.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   8'(bus0.busy), 8'd0);
    chk({tag, "_load"},   8'(bus0.input_load_en), 8'd0);
    chk({tag, "_au"},     8'(bus0.AU_en), 8'd0);
    chk({tag, "_rom"},    8'(bus0.rom_addr), 8'd0);
    chk({tag, "_ram"},    bus0.ram_addr, 8'h00);
    chk({tag, "_ram_fe"}, bus1.ram_addr, 8'hFE);
    chk({tag, "_cs_n"},   8'(bus0.cs_n), 8'd1);
    chk({tag, "_we_n"},   8'(bus0.we_n), 8'd1);
    chk({tag, "_rowdn"},  8'(bus0.row_done), 8'd0);
    chk({tag, "_avg"},    8'(bus0.avgmax_en), 8'd0);
    chk({tag, "_done"},   8'(bus0.done), 8'd0);
  endtask

  // Runs one full job; entered and left on a falling edge with the DUT idle.
  task automatic run_job(input int stall_row, input int stall_len, input bit poke);
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    #1;
    chk("accept_busy_before", 8'(bus0.busy), 8'd0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("load_en", 8'(bus0.input_load_en), 8'd1);
      chk("load_busy", 8'(bus0.busy), 8'd1);
      chk("load_au", 8'(bus0.AU_en), 8'd0);
      @(negedge clk);
    end
    xload_done = 1'b1;
    #1;
    chk("load_en_last", 8'(bus0.input_load_en), 8'd1);
    @(negedge clk);
    xload_done = 1'b0;
    for (int r = 0; r < NR; r++) begin
      for (int m = 0; m < NM; m++) begin
        ry = 1'b1;
        start = poke && (m == 1);
        #1;
        chk("mac_au", 8'(bus0.AU_en), 8'd1);
        chk("mac_rom", 8'(bus0.rom_addr), 8'(r * NM + m));
        chk("mac_cs_n", 8'(bus0.cs_n), 8'd1);
        chk("mac_ram", bus0.ram_addr, 8'h00);
        @(negedge clk);
        start = 1'b0;
      end
      if (r == stall_row) begin
        for (int s = 0; s < stall_len; s++) begin
          ry = 1'b0;
          start = poke;
          #1;
          chk("stall_cs_n", 8'(bus0.cs_n), 8'd1);
          chk("stall_we_n", 8'(bus0.we_n), 8'd1);
          chk("stall_rowdn", 8'(bus0.row_done), 8'd0);
          chk("stall_au", 8'(bus0.AU_en), 8'd0);
          chk("stall_busy", 8'(bus0.busy), 8'd1);
          @(negedge clk);
          start = 1'b0;
        end
      end
      ry = 1'b1;
      #1;
      chk("wb_cs_n", 8'(bus0.cs_n), 8'd0);
      chk("wb_we_n", 8'(bus0.we_n), 8'd0);
      chk("wb_rowdn", 8'(bus0.row_done), 8'd1);
      chk("wb_ram", bus0.ram_addr, 8'(r));
      chk("wb_ram_fe", bus1.ram_addr, 8'(8'hFE + r));
      chk("wb_au", 8'(bus0.AU_en), 8'd0);
      chk("wb_avg", 8'(bus0.avgmax_en), 8'd0);
      @(negedge clk);
    end
    ry = 1'b0;
`ifdef MATMUL_CTRL_AVGMAX_EN
    #1;
    chk("post_avg", 8'(bus0.avgmax_en), 8'd1);
    chk("post_done", 8'(bus0.done), 8'd0);
    chk("post_cs_n", 8'(bus0.cs_n), 8'd1);
    @(negedge clk);
`endif
    #1;
    chk("done_pulse", 8'(bus0.done), 8'd1);
    chk("done_avg", 8'(bus0.avgmax_en), 8'd0);
    chk("done_busy", 8'(bus0.busy), 8'd1);
    @(negedge clk);
    #1;
    chk("after_done", 8'(bus0.done), 8'd0);
    chk("after_busy", 8'(bus0.busy), 8'd0);
    chk("done_count", 8'(done_cnt - d0), 8'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    xload_done = 1'b0;
    ry = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");

    // Out-of-state xload_done/ry must not move an idle controller
    @(negedge clk);
    rst = 1'b1;
    xload_done = 1'b1;
    ry = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_idle_outputs("idle_ignore");
    xload_done = 1'b0;
    ry = 1'b0;
    @(negedge clk);

    // Plain job, then one with a 5-cycle ready stall in row 2 and stray starts
    run_job(-1, 0, 1'b0);
    run_job(2, 5, 1'b1);

    // Reset in the middle of MAC row 1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xload_done = 1'b1;
    @(negedge clk);
    xload_done = 1'b0;
    ry = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("pre_rst_au", 8'(bus0.AU_en), 8'd1);
    chk("pre_rst_rom", 8'(bus0.rom_addr), 8'd5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_idle_outputs("midmac_rst");
    @(negedge clk);
    rst = 1'b1;
    run_job(-1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter N_MUL, default 4, MAC cycles per output row (1..8).
REQ-002 SHALL have parameter N_ROWS, default 4, output rows per X set (1..16, N_ROWS*N_MUL <= 16).
REQ-003 SHALL have parameter RAM_BASE, default 8'h00, first SRAM word address written.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a job.
REQ-007 xload_done  in  1  X buffer filled.
REQ-008 ry  in  1  SRAM ready for an access.
REQ-009 input_load_en  out  1  enables X buffer loading.
REQ-010 AU_en  out  1  enables ALU multiply-accumulate.
REQ-011 rom_addr  out  4  coefficient ROM address.
REQ-012 cs_n, we_n  out  1 each  SRAM chip select / write enable, active-low.
REQ-013 ram_addr  out  8  SRAM write address.
REQ-014 row_done  out  1  one-cycle pulse per row written.
REQ-015 avgmax_en  out  1  post-processing enable (see Configuration).
REQ-016 busy, done  out  1 each  job in progress; one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, MAC, WB, POST, DONE.
REQ-018 IDLE: start=1 -> LOAD next cycle; row counter and mul counter cleared.
REQ-019 LOAD: input_load_en=1; xload_done=1 -> MAC next cycle.
REQ-020 MAC: AU_en=1 for exactly N_MUL consecutive cycles; rom_addr = row*N_MUL + mul (combinational from registered counters); after mul=N_MUL-1 -> WB.
REQ-021 WB: cs_n=0 and we_n=0 only while ry=1; ram_addr = RAM_BASE + row; state held while ry=0 with cs_n=we_n=1.
REQ-022 WB write cycle (ry=1): row_done=1 that cycle; row<N_ROWS-1 -> row+1, MAC; else -> POST (macro set) or DONE.
REQ-023 DONE: done=1 for one cycle -> IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start while busy SHALL be ignored, not queued.
REQ-026 ram_addr SHALL wrap modulo 256 (RAM_BASE + row overflow).
REQ-027 Outside their states: input_load_en=AU_en=avgmax_en=row_done=done=0, cs_n=we_n=1, rom_addr=0, ram_addr=RAM_BASE.
REQ-028 xload_done outside LOAD and ry outside WB SHALL have no effect.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE, counters 0, and all outputs to REQ-027 values, regardless of state (incl. mid-MAC or mid-WB).
REQ-030 First clock edge with rst=1 SHALL be able to accept start.

Configuration
REQ-031 Macro MATMUL_CTRL_AVGMAX_EN defined: after last WB, POST asserts avgmax_en=1 for exactly one cycle, then DONE.
REQ-032 Macro undefined: POST unreachable, avgmax_en tied 0, last WB goes directly to DONE.

Structure
REQ-033 State encoding enum and default parameter constants SHALL live in shared package matmul_pkg.
REQ-034 A sub-module matmul_addr_gen SHALL hold row/mul counters and produce rom_addr, ram_addr, last_mul, last_row.

Verification
REQ-035 Defaults, start, xload_done 3 cycles later, ry=1 -> AU_en 4 cycles per row, rom_addr 0..15 in order, 4 writes to addr 0..3, done once.
REQ-036 ry=0 for 5 cycles in row 2 WB -> cs_n/we_n stay 1, state held; write to addr 2 on first ry=1 cycle.
REQ-037 rst=0 during MAC row 1 -> next cycle IDLE, all outputs REQ-027 values; new start runs full job from row 0.
REQ-038 start pulses during MAC and WB -> ignored; exactly one done per accepted start.
REQ-039 RAM_BASE=8'hFE, N_ROWS=4 -> ram_addr FE, FF, 00, 01.
REQ-040 With and without MATMUL_CTRL_AVGMAX_EN -> avgmax_en one cycle between last row_done and done, or never high; done one cycle later when defined.
